// File: rtl/bi_set_reg_bank.sv
// BiSet register bank: LENGTH registers at ADDR..ADDR+LENGTH-1, each RW (optionally shadowed
// behind a commit strobe) or W1C hardware status. Bus: setCtrl_i = {strobe, write, addr[15:0]}, setReply_o = {ack, rdata[31:0]}.

module bi_set_reg_lane #(
  parameter int              WIDTH  = 32,
  parameter logic [WIDTH-1:0] RST   = '0,
  parameter bit              W1C    = 1'b0,
  parameter bit              SHADOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hit,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] hw_set,
  input  logic             commit,
  output logic [WIDTH-1:0] val,
  output logic             evt,
  output logic             dirty,
  output logic [32:0]      reply
);
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] rd_val;
  logic             wr, rd;
  logic             unused_lane;

  assign wr          = hit & we;
  assign rd          = hit & ~we;
  assign rd_val      = (SHADOW && !W1C) ? shadow : val;
  assign unused_lane = ^{hw_set, commit};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val    <= RST;
      shadow <= RST;
      dirty  <= 1'b0;
      evt    <= 1'b0;
      reply  <= '0;
    end else begin
      evt   <= 1'b0;
      // Write replies carry zero data so the bank-level OR merge stays clean.
      reply <= {hit, rd ? 32'(rd_val) : 32'd0};
      if (W1C) begin
        val <= (val & ~(wr ? wdata : '0)) | hw_set;
        evt <= wr;
      end else if (SHADOW) begin
        // Commit applies the pre-write shadow; a same-cycle write stays pending.
        if (commit && dirty) begin
          val <= shadow;
          evt <= 1'b1;
        end
        if (wr) begin
          shadow <= wdata;
          dirty  <= 1'b1;
        end else if (commit) begin
          dirty <= 1'b0;
        end
      end else if (wr) begin
        val <= wdata;
        evt <= 1'b1;
      end
    end
  end
endmodule

module bi_set_reg_bank #(
  parameter logic [15:0]       ADDR     = 16'd1,
  parameter int                LENGTH   = 2,
  parameter int                WIDTH    = 32,
  parameter logic [31:0]       RESET    = '0,
  parameter logic [LENGTH-1:0] W1C_MASK = '0,
  parameter bit                SHADOW   = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic [LENGTH-1:0][WIDTH-1:0]  val_o,
  output logic [LENGTH-1:0]             event_o,
  input  logic [LENGTH-1:0][WIDTH-1:0]  hwSet_i,
  input  logic                          commit_i,
  output logic                          pending_o,
  input  logic [17:0]                   setCtrl_i,
  input  logic [31:0]                   setWrite_i,
  output logic [32:0]                   setReply_o
);
  logic [LENGTH-1:0]        dirty;
  logic [LENGTH-1:0][32:0]  lane_reply;
  logic                     unused_top;

  assign unused_top = ^setWrite_i;
  assign pending_o  = |dirty;

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    localparam logic [15:0] LA = ADDR + 16'(i);
    logic hit;
    assign hit = setCtrl_i[17] && (setCtrl_i[15:0] == LA);

    bi_set_reg_lane #(
      .WIDTH  (WIDTH),
      .RST    (RESET[WIDTH-1:0]),
      .W1C    (W1C_MASK[i]),
      .SHADOW (SHADOW)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .hit    (hit),
      .we     (setCtrl_i[16]),
      .wdata  (setWrite_i[WIDTH-1:0]),
      .hw_set (hwSet_i[i]),
      .commit (commit_i),
      .val    (val_o[i]),
      .evt    (event_o[i]),
      .dirty  (dirty[i]),
      .reply  (lane_reply[i])
    );
  end

  // Only the addressed lane can drive a nonzero reply, so OR is a lossless merge.
  always_comb begin
    setReply_o = '0;
    for (int i = 0; i < LENGTH; i++) setReply_o = setReply_o | lane_reply[i];
  end
endmodule
